// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave keypad receive path.
package microwave_pkg;

  localparam int unsigned DIGIT_W      = 4;
  localparam int unsigned COUNT_W      = 2;
  localparam int unsigned BCD_MAX      = 9;
  localparam int unsigned SEC_TENS_MAX = 5;
  localparam int unsigned DIGITS       = 3;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_LOCKED = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] mins;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } setpoint_t;

  // Keypad-style entry: new digit enters on the right, oldest falls off the left.
  function automatic setpoint_t shift_digit(input setpoint_t sp, input logic [DIGIT_W-1:0] d);
    setpoint_t r;
    r.mins     = sp.sec_tens;
    r.sec_tens = sp.sec_ones;
    r.sec_ones = d;
    return r;
  endfunction

endpackage

// File: rtl/strobe_sync_edge.sv
// Synchronizes the encoder strobe and load into the clock domain and detects the strobe rising edge.
module strobe_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic pgt,
  input  logic loadn,
  output logic strobe,
  output logic loadn_sync
);

  logic [SYNC_STAGES-1:0] pgt_q;
  logic [SYNC_STAGES-1:0] loadn_q;
  logic                   pgt_hist;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      pgt_q    <= '0;
      loadn_q  <= '0;
      pgt_hist <= 1'b0;
    end else begin
      pgt_q    <= {pgt_q[SYNC_STAGES-2:0], pgt};
      loadn_q  <= {loadn_q[SYNC_STAGES-2:0], loadn};
      pgt_hist <= pgt_q[SYNC_STAGES-1];
    end
  end

  assign strobe     = pgt_q[SYNC_STAGES-1] & ~pgt_hist;
  assign loadn_sync = loadn_q[SYNC_STAGES-1];

endmodule

// File: rtl/keypad_digit_receiver.sv
// Assembles strobed keypad digits into a three-digit M:ST:SO setpoint, with lockout while the magnetron runs.
module keypad_digit_receiver
  import microwave_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clearn,
  input  logic               enable,
  input  logic [DIGIT_W-1:0] number,
  input  logic               loadn,
  input  logic               pgt,
  output logic [DIGIT_W-1:0] mins,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic [COUNT_W-1:0] digit_count,
  output logic               entry_valid,
  output logic               digit_err
);

  rx_state_e          state, state_next;
  setpoint_t          sp, sp_next;
  logic [COUNT_W-1:0] count, count_next;
  logic               err, err_next;
  logic               clear;
  logic               strobe;
  logic               loadn_sync;
  logic               digit_strobe;
  logic               digit_ok;

  assign clear = ~clearn;

  strobe_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .pgt        (pgt),
    .loadn      (loadn),
    .strobe     (strobe),
    .loadn_sync (loadn_sync)
  );

  assign digit_strobe = strobe & ~loadn_sync;
  assign digit_ok     = (number <= DIGIT_W'(BCD_MAX));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_EMPTY;
      sp    <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      sp    <= sp_next;
      count <= count_next;
      err   <= err_next;
    end
  end

  // Priority: clear, then lockout, then strobe; a digit may land in the cycle lockout ends.
  always_comb begin
    state_next = state;
    sp_next    = sp;
    count_next = count;
    err_next   = 1'b0;
    if (clear) begin
      sp_next    = '0;
      count_next = '0;
      state_next = enable ? ST_LOCKED : ST_EMPTY;
    end else if (enable) begin
      state_next = ST_LOCKED;
    end else begin
      case (state)
        ST_LOCKED: state_next = (count != '0) ? ST_ENTRY : ST_EMPTY;
        default:   state_next = state;
      endcase
      if (digit_strobe) begin
        if (digit_ok) begin
          sp_next    = shift_digit(sp, number);
          count_next = (count == COUNT_W'(DIGITS)) ? count : count + COUNT_W'(1);
          state_next = ST_ENTRY;
        end else begin
          err_next = 1'b1;
        end
      end
    end
  end

  assign mins        = sp.mins;
  assign sec_tens    = sp.sec_tens;
  assign sec_ones    = sp.sec_ones;
  assign digit_count = count;
  assign digit_err   = err;
  assign entry_valid = (sp != '0) && (sp.sec_tens <= DIGIT_W'(SEC_TENS_MAX));

endmodule

// File: tb/tb_keypad_digit_receiver.sv
// Scoreboard bench for keypad_digit_receiver: stimulus queues expected output tuples, a monitor pops on every output change.
module tb_keypad_digit_receiver;

  typedef struct packed {
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] o;
    logic [1:0] c;
    logic       v;
    logic       e;
  } obs_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clearn = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] number = 4'd0;
  logic       loadn = 1'b1;
  logic       pgt = 1'b0;
  logic [3:0] mins, sec_tens, sec_ones;
  logic [1:0] digit_count;
  logic       entry_valid, digit_err;

  obs_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  int   ev_cycle = 0;
  bit   mon_en = 1'b0;
  bit   first = 1'b1;
  obs_t prev;
  int   n_edge;

  keypad_digit_receiver #(.SYNC_STAGES(2)) dut (
    .clock       (clock),
    .reset       (reset),
    .clearn      (clearn),
    .enable      (enable),
    .number      (number),
    .loadn       (loadn),
    .pgt         (pgt),
    .mins        (mins),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .digit_count (digit_count),
    .entry_valid (entry_valid),
    .digit_err   (digit_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every change of the observable tuple must match the head of the scoreboard.
  always @(negedge clock) begin
    obs_t cur;
    obs_t exp;
    if (mon_en) begin
      cur = {mins, sec_tens, sec_ones, digit_count, entry_valid, digit_err};
      if (first || cur != prev) begin
        ev_cycle = cyc;
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_output: got m=%0d t=%0d o=%0d cnt=%0d valid=%0b err=%0b, required no change",
                   cur.m, cur.t, cur.o, cur.c, cur.v, cur.e);
        end else begin
          exp = sb.pop_front();
          if (cur !== exp)
            $display("FAIL output_tuple: got m=%0d t=%0d o=%0d cnt=%0d valid=%0b err=%0b, required m=%0d t=%0d o=%0d cnt=%0d valid=%0b err=%0b",
                     cur.m, cur.t, cur.o, cur.c, cur.v, cur.e, exp.m, exp.t, exp.o, exp.c, exp.v, exp.e);
          else
            passes++;
        end
      end
      prev  = cur;
      first = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o,
                      input logic [1:0] c, input logic v, input logic e);
    obs_t x;
    x = {m, t, o, c, v, e};
    sb.push_back(x);
  endtask

  // Full encoder handshake: data and load settle, pgt high for 'hold' cycles, then release.
  task automatic strobe(input logic [3:0] d, input logic ld, input int hold, output int edge_n);
    number = d;
    loadn  = ld;
    repeat (3) tick();
    pgt    = 1'b1;
    edge_n = cyc + 1;
    repeat (hold) tick();
    pgt    = 1'b0;
    repeat (4) tick();
    loadn  = 1'b1;
  endtask

  task automatic clear_pulse();
    clearn = 1'b0;
    tick();
    clearn = 1'b1;
    tick();
  endtask

  task automatic drain(input string name);
    repeat (6) tick();
    checks++;
    if (sb.size() == 0) passes++;
    else begin
      $display("FAIL drain_%s: %0d expected events never seen, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int e;
    // Reset state
    push(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (2) tick();

    // Basic entry 1,3,0 with latency check on the first digit
    push(0, 0, 1, 1, 1, 0);
    strobe(4'd1, 1'b0, 2, e);
    checks++;
    if (ev_cycle == e + 2) passes++;
    else $display("FAIL latency: update at cycle %0d, required %0d", ev_cycle, e + 2);
    push(0, 1, 3, 2, 1, 0);
    strobe(4'd3, 1'b0, 2, e);
    push(1, 3, 0, 3, 1, 0);
    strobe(4'd0, 1'b0, 2, e);
    drain("basic");

    // Overflow shift
    push(0, 0, 0, 0, 0, 0);
    clear_pulse();
    push(0, 0, 1, 1, 1, 0); strobe(4'd1, 1'b0, 2, e);
    push(0, 1, 2, 2, 1, 0); strobe(4'd2, 1'b0, 2, e);
    push(1, 2, 3, 3, 1, 0); strobe(4'd3, 1'b0, 2, e);
    push(2, 3, 4, 3, 1, 0); strobe(4'd4, 1'b0, 2, e);
    push(3, 4, 7, 3, 1, 0); strobe(4'd7, 1'b0, 2, e);
    push(4, 7, 5, 3, 0, 0); strobe(4'd5, 1'b0, 2, e);
    drain("overflow");

    // Bad digit: one-cycle error pulse, setpoint held
    push(0, 0, 0, 0, 0, 0);
    clear_pulse();
    push(0, 0, 5, 1, 1, 0); strobe(4'd5, 1'b0, 2, e);
    push(0, 0, 5, 1, 1, 1);
    push(0, 0, 5, 1, 1, 0);
    strobe(4'hC, 1'b0, 2, e);
    drain("bad_digit");

    // Long strobe gives one shift; loadn high gives none
    push(0, 5, 6, 2, 1, 0);
    strobe(4'd6, 1'b0, 20, e);
    strobe(4'd2, 1'b1, 2, e);
    drain("long_loadn");

    // Lockout
    push(0, 0, 0, 0, 0, 0);
    clear_pulse();
    push(0, 0, 0, 1, 0, 0); strobe(4'd0, 1'b0, 2, e);
    push(0, 0, 4, 2, 1, 0); strobe(4'd4, 1'b0, 2, e);
    push(0, 4, 5, 3, 1, 0); strobe(4'd5, 1'b0, 2, e);
    enable = 1'b1;
    tick();
    strobe(4'd9, 1'b0, 2, e);
    push(0, 0, 0, 0, 0, 0);
    clear_pulse();
    enable = 1'b0;
    tick();
    drain("lockout");
    push(0, 0, 2, 1, 1, 0);
    strobe(4'd2, 1'b0, 2, e);

    // Reset mid-entry: reset lands on the strobe-detect cycle
    push(0, 2, 3, 2, 1, 0);
    strobe(4'd3, 1'b0, 2, e);
    drain("pre_reset");
    push(0, 0, 0, 0, 0, 0);
    number = 4'd8;
    loadn  = 1'b0;
    repeat (3) tick();
    pgt = 1'b1;
    tick();
    tick();
    pgt   = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    loadn = 1'b1;
    drain("reset_drop");
    push(0, 0, 8, 1, 1, 0);
    strobe(4'd8, 1'b0, 2, e);
    drain("after_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
